cpack_code_parser: RTL
======================

# cpack_code_parser

Decompression-side front end of the C-Pack datapath. Accepts the packed compressed bitstream as 32-bit words, LSB-first, and splits it back into individual variable-length codes. Each code is emitted as a 3-bit pattern code, a dictionary index and the literal bits, using the same pattern encoding the compressor's code concatenation stage produces. It feeds the dictionary/word-reconstruction stage through a valid/ready handshake.

## Interface
- DATA_WIDTH, 32, input stream word and literal width
- BUF_BITS, 72, bit buffer depth; must be ≥ DATA_WIDTH+40
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_data  input  DATA_WIDTH  next 32 stream bits; bit 0 is the earliest bit
- i_valid  input  1  i_data valid
- o_ready  output  1  parser can accept i_data this cycle
- i_flush  input  1  one-cycle pulse; discard all buffered bits and clear error
- o_valid  output  1  decoded code available
- i_ready  input  1  downstream accepts the code
- o_code  output  3  000 zzzz, 001 mmmm, 010 zzzx, 011 mmmx, 100 mmxx, 101 xxxx
- o_dict_idx  output  4  dictionary index; 0 for zzzz, zzzx, xxxx
- o_word  output  DATA_WIDTH  literal bits, zero-extended: byte for zzzx/mmmx, halfword for mmxx, full word for xxxx, 0 otherwise
- o_len  output  6  bit length of the current code
- o_err  output  1  sticky illegal-prefix flag

## Operation
- The bit buffer holds `fill` valid bits. The head is at bit 0.
- Prefix decode from the head, LSB-first:
  - b[1:0]=00 → zzzz, 2 bits.
  - b[1:0]=10 → mmmm, 6 bits; idx=b[5:2].
  - b[1:0]=01 → xxxx, 34 bits; word=b[33:2].
  - b[1:0]=11 → read b[3:2]:
    - 01 → zzzx, 12 bits; byte=b[11:4].
    - 10 → mmmx, 16 bits; idx=b[7:4], byte=b[15:8].
    - 00 → mmxx, 24 bits; idx=b[7:4], half=b[23:8].
    - 11 → illegal.
- o_valid=1 only when all of the following hold:
  - fill ≥ 2, and fill ≥ 4 if b[1:0]=11;
  - fill ≥ the decoded length;
  - o_err=0.
- o_code, o_dict_idx, o_word and o_len are forced to 0 whenever o_valid=0.
- Code consume: when o_valid && i_ready, the buffer shifts right by o_len and fill decreases by o_len.
- Word accept: o_ready = (fill ≤ BUF_BITS−32) && !o_err. When i_valid && o_ready, i_data is written at bit position fill (after any same-cycle consume shift) and fill increases by 32.
- Simultaneous consume and accept in one cycle: new fill = fill − o_len + 32, and i_data lands at position fill − o_len.
- Deadlock freedom: whenever o_ready=0 with no error, fill > 40 ≥ 34, so a full code is always decodable.
- Illegal prefix 1111 (with fill ≥ 4): o_err is set on the next edge. After that, o_valid=0 and o_ready=0 until i_flush or reset.
- i_flush has priority over consume and accept in the same cycle. It sets fill=0 and o_err=0, and the i_data offered in that cycle is not accepted.
- Bits left at the end of a block (fewer than a full code) remain buffered until more data arrives or i_flush.

## Timing
- Reset (asynchronous assertion): fill=0, buffer=0, o_err=0. This gives o_valid=0, o_ready=1 and all data outputs 0.
- All outputs are decoded combinationally from registered state only. There is no combinational path from i_data/i_valid/i_ready to any output.
- Latency: a word accepted at edge N can produce o_valid in the cycle after edge N.
- Throughput: at most one code out and one word in per cycle.
- When o_valid && !i_ready, all outputs stay stable. Accepting input never alters the current head code.
- Reset asserted mid-stream drops all buffered bits. The next code decoded after reset starts at bit 0 of the first word accepted after reset.

## Test plan
- mmmm then zero tail: i_data=0x00000016, i_ready=1.
  - Expect mmmm, idx=5, len=6.
  - Then 13 consecutive zzzz codes (len=2).
  - Then o_valid=0 with fill=0.
- xxxx spanning two words: send 0x7AB6FBBD.
  - Expect o_valid=0 (fill=32 < 34).
  - Then send 0x00000003. Expect xxxx, o_word=0xDEADBEEF, len=34, with the remaining 30 bits decoding as 15 zzzz codes.
- Mixed codes: i_data=0x00000A57, i_ready=1.
  - Expect zzzx, o_word=0x000000A5, len=12.
  - Then 10 zzzz codes.
- Backpressure: hold i_ready=0 and stream words.
  - o_ready drops once fill > 40.
  - Head outputs stay constant.
  - Releasing i_ready resumes decoding with no lost or duplicated bits.
- Illegal prefix: i_data=0x0000000F.
  - o_err=1 on the next cycle; o_valid=0; o_ready=0.
  - Pulse i_flush: o_err=0, o_ready=1, fill=0.
- Reset mid-stream: assert i_rst_n low with fill=20.
  - Outputs are immediately at reset values.
  - After release, 0x00000016 decodes as mmmm idx=5.

Source files
------------

// File: rtl/cpack_code_parser.sv
// C-Pack decompression front end: buffers the LSB-first packed bitstream and
// splits it into pattern code, dictionary index and literal per variable-length code.
module cpack_code_parser #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BUF_BITS   = 72
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_flush,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [2:0]            o_code,
    output logic [3:0]            o_dict_idx,
    output logic [DATA_WIDTH-1:0] o_word,
    output logic [5:0]            o_len,
    output logic                  o_err
);

    localparam int unsigned FILL_W = $clog2(BUF_BITS + 1);
    localparam int unsigned LEN_W  = 6;

    localparam logic [2:0] CODE_ZZZZ = 3'd0;
    localparam logic [2:0] CODE_MMMM = 3'd1;
    localparam logic [2:0] CODE_ZZZX = 3'd2;
    localparam logic [2:0] CODE_MMMX = 3'd3;
    localparam logic [2:0] CODE_MMXX = 3'd4;
    localparam logic [2:0] CODE_XXXX = 3'd5;

    logic [BUF_BITS-1:0]   buf_q, buf_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic                  err_q, err_d;

    logic [2:0]            dec_code;
    logic [3:0]            dec_idx;
    logic [DATA_WIDTH-1:0] dec_word;
    logic [LEN_W-1:0]      dec_len;
    logic                  dec_illegal;
    logic                  prefix_ok;
    logic                  head_valid;
    logic                  set_err;
    logic                  consume;
    logic                  accept;
    logic [FILL_W-1:0]     shamt;
    logic [BUF_BITS-1:0]   buf_shift;
    logic [FILL_W-1:0]     fill_shift;

    // Prefix decode of the code sitting at the buffer head
    always_comb begin
        dec_code    = CODE_ZZZZ;
        dec_idx     = '0;
        dec_word    = '0;
        dec_len     = '0;
        dec_illegal = 1'b0;
        case (buf_q[1:0])
            2'b00: begin
                dec_code = CODE_ZZZZ;
                dec_len  = LEN_W'(2);
            end
            2'b10: begin
                dec_code = CODE_MMMM;
                dec_idx  = buf_q[5:2];
                dec_len  = LEN_W'(6);
            end
            2'b01: begin
                dec_code = CODE_XXXX;
                dec_word = buf_q[DATA_WIDTH+1:2];
                dec_len  = LEN_W'(DATA_WIDTH + 2);
            end
            default: begin
                case (buf_q[3:2])
                    2'b01: begin
                        dec_code = CODE_ZZZX;
                        dec_word = DATA_WIDTH'(buf_q[11:4]);
                        dec_len  = LEN_W'(12);
                    end
                    2'b10: begin
                        dec_code = CODE_MMMX;
                        dec_idx  = buf_q[7:4];
                        dec_word = DATA_WIDTH'(buf_q[15:8]);
                        dec_len  = LEN_W'(16);
                    end
                    2'b00: begin
                        dec_code = CODE_MMXX;
                        dec_idx  = buf_q[7:4];
                        dec_word = DATA_WIDTH'(buf_q[23:8]);
                        dec_len  = LEN_W'(24);
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    // A 11-prefix needs four bits before its length is even known
    assign prefix_ok  = (fill_q >= FILL_W'(2)) &&
                        ((buf_q[1:0] != 2'b11) || (fill_q >= FILL_W'(4)));
    assign head_valid = prefix_ok && !dec_illegal && !err_q &&
                        (fill_q >= FILL_W'(dec_len));
    assign set_err    = prefix_ok && dec_illegal;

    assign o_valid    = head_valid;
    assign o_ready    = (fill_q <= FILL_W'(BUF_BITS - DATA_WIDTH)) && !err_q;
    assign o_err      = err_q;
    assign o_code     = head_valid ? dec_code : 3'd0;
    assign o_dict_idx = head_valid ? dec_idx  : 4'd0;
    assign o_word     = head_valid ? dec_word : '0;
    assign o_len      = head_valid ? dec_len  : 6'd0;

    assign consume = head_valid && i_ready;
    assign accept  = i_valid && o_ready;

    // Consume shift first, then append the new word just above the survivors
    always_comb begin
        shamt      = consume ? FILL_W'(dec_len) : '0;
        buf_shift  = buf_q >> shamt;
        fill_shift = fill_q - shamt;
        buf_d      = buf_shift;
        fill_d     = fill_shift;
        err_d      = err_q | set_err;
        if (accept) begin
            buf_d  = buf_shift | (BUF_BITS'(i_data) << fill_shift);
            fill_d = fill_shift + FILL_W'(DATA_WIDTH);
        end
        if (i_flush) begin
            buf_d  = '0;
            fill_d = '0;
            err_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            buf_q  <= '0;
            fill_q <= '0;
            err_q  <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
            err_q  <= err_d;
        end
    end

endmodule
